// File: rtl/conv1d_pkg.sv
// Shared types and arithmetic helpers for the streaming 1-D convolver.
package conv1d_pkg;

    typedef enum logic [1:0] {
        LOAD_F  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    // Width of the generic saturation datapath; covers any ACCW up to 64.
    localparam int SAT_W = 64;

    function automatic int calc_accw(input int width, input int lenf);
        return 2 * width + $clog2(lenf);
    endfunction

    function automatic int calc_ngroup(input int size, input int p);
        return (size + p - 1) / p;
    endfunction

    // Values for the default configuration (WIDTH=16, LENX=16, LENF=4, P=2).
    localparam int ACCW   = calc_accw(16, 4);
    localparam int NGROUP = calc_ngroup(13, 2);

    // Clamp a full-precision sum into a signed width-bit range, then
    // optionally zero negative results; caller keeps the low width bits.
    function automatic logic signed [SAT_W-1:0] sat_relu(
        input logic signed [SAT_W-1:0] acc,
        input logic                    relu,
        input int                      width
    );
        logic signed [SAT_W-1:0] hi, lo, r;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (acc > hi)      r = hi;
        else if (acc < lo) r = lo;
        else               r = acc;
        if (relu && (r < 64'sd0)) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One multiply-accumulate lane. acc presents the running sum including the
// current cycle's product, so the controller can write back on the last tap.
module conv_mac_lane #(
    parameter int WIDTH = 16,
    parameter int ACCW  = 34
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] f,
    output logic signed [ACCW-1:0]  acc
);

    logic signed [ACCW-1:0]    acc_q;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACCW-1:0]    base;

    // Full-precision product added to either zero (first tap) or the held sum.
    always_comb begin
        prod = x * f;
        base = clr ? '0 : acc_q;
        acc  = en ? base + ACCW'(prod) : base;
    end

    // Hold the partial sum between taps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc_q <= '0;
        else        acc_q <= acc;
    end

endmodule

// File: rtl/conv1d_stream_p.sv
// Streaming valid-mode 1-D convolver: runtime-loaded filter, P parallel MAC
// lanes, single final saturation, optional ReLU, output buffer that drains
// while the next X frame loads.
module conv1d_stream_p
    import conv1d_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int LENX  = 16,
    parameter  int LENF  = 4,
    parameter  int P     = 2,
    localparam int SIZE  = LENX - LENF + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_f,
    input  logic             s_valid_f,
    output logic             s_ready_f,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    input  logic             relu_en,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    localparam int ACC_W   = calc_accw(WIDTH, LENF);
    localparam int N_GROUP = calc_ngroup(SIZE, P);
    localparam int XCW     = $clog2(LENX + 1);
    localparam int FCW     = $clog2(LENF + 1);
    localparam int PW      = $clog2(SIZE + 1);
    localparam int GW      = $clog2(N_GROUP + 1);
    localparam int XIW     = (LENX > 1) ? $clog2(LENX) : 1;
    localparam int KW      = (LENF > 1) ? $clog2(LENF) : 1;
    localparam int IW      = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t                  state;
    logic [XCW-1:0]          xcnt;
    logic [FCW-1:0]          fcnt;
    logic [GW-1:0]           g;
    logic [KW-1:0]           k;
    logic [PW-1:0]           rd, wr, rd_nx, wr_nx, n_wr;
    logic                    relu_q;
    logic signed [WIDTH-1:0] xbuf [LENX];
    logic signed [WIDTH-1:0] fbuf [LENF];
    logic [WIDTH-1:0]        obuf [SIZE];

    logic                        hs_f, hs_x, hs_y, last_tap, x_full_nx, empty_nx;
    logic [P-1:0]                lane_on;
    logic [P-1:0][WIDTH-1:0]     lane_x;
    logic [P-1:0][WIDTH-1:0]     lane_y;
    logic signed [ACC_W-1:0]     lane_acc [P];

    assign s_ready_f    = (state == LOAD_F);
    assign s_ready_x    = (state == LOAD_X) && (xcnt < XCW'(LENX));
    assign m_valid_y    = (rd < wr);
    assign m_data_out_y = obuf[rd[IW-1:0]];
    assign hs_f         = s_valid_f & s_ready_f;
    assign hs_x         = s_valid_x & s_ready_x;
    assign hs_y         = m_valid_y & m_ready_y;
    assign last_tap     = (state == COMPUTE) && (k == KW'(LENF - 1));
    assign x_full_nx    = (xcnt == XCW'(LENX)) || (hs_x && (xcnt == XCW'(LENX - 1)));

    // Lane i of group g owns y[g*P+i]; lanes past SIZE stay cleared.
    for (genvar i = 0; i < P; i++) begin : g_lane
        logic [31:0] yi, xi;
        always_comb begin
            yi = 32'(g) * 32'(P) + 32'(i);
            xi = yi + 32'(k);
        end
        assign lane_on[i] = (state == COMPUTE) && (yi < 32'(SIZE));
        assign lane_x[i]  = (xi < 32'(LENX)) ? xbuf[xi[XIW-1:0]] : '0;
        assign lane_y[i]  = WIDTH'(sat_relu(SAT_W'(lane_acc[i]), relu_q, WIDTH));

        conv_mac_lane #(.WIDTH(WIDTH), .ACCW(ACC_W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   ((k == '0) || !lane_on[i]),
            .en    (lane_on[i]),
            .x     (lane_x[i]),
            .f     (fbuf[k]),
            .acc   (lane_acc[i])
        );
    end

    // Next pointer values: group write advances wr, a drain of the last
    // entry clears both so the buffer reads as empty again.
    always_comb begin
        n_wr = '0;
        for (int i = 0; i < P; i++) n_wr = n_wr + PW'(lane_on[i]);
        rd_nx = rd;
        wr_nx = wr;
        if (last_tap) wr_nx = wr + n_wr;
        if (hs_y) begin
            rd_nx = rd + PW'(1);
            if (rd_nx == PW'(SIZE)) begin
                rd_nx = '0;
                wr_nx = '0;
            end
        end
        empty_nx = (rd_nx == '0) && (wr_nx == '0);
    end

    // Controller: filter load, X frame load, grouped MAC sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= LOAD_F;
            xcnt   <= '0;
            fcnt   <= '0;
            g      <= '0;
            k      <= '0;
            relu_q <= 1'b0;
            for (int i = 0; i < LENX; i++) xbuf[i] <= '0;
            for (int i = 0; i < LENF; i++) fbuf[i] <= '0;
        end else begin
            case (state)
                LOAD_F: if (hs_f) begin
                    fbuf[fcnt[KW-1:0]] <= s_data_in_f;
                    if (fcnt == FCW'(LENF - 1)) begin
                        fcnt  <= '0;
                        state <= LOAD_X;
                    end else begin
                        fcnt <= fcnt + FCW'(1);
                    end
                end
                LOAD_X: begin
                    if (hs_x) begin
                        xbuf[xcnt[XIW-1:0]] <= s_data_in_x;
                        xcnt                <= xcnt + XCW'(1);
                        if (xcnt == '0) relu_q <= relu_en;
                    end
                    if (x_full_nx && empty_nx) begin
                        state <= COMPUTE;
                        g     <= '0;
                        k     <= '0;
                    end
                end
                COMPUTE: begin
                    if (last_tap) begin
                        k <= '0;
                        if (g == GW'(N_GROUP - 1)) begin
                            g     <= '0;
                            xcnt  <= '0;
                            state <= LOAD_X;
                        end else begin
                            g <= g + GW'(1);
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= LOAD_F;
            endcase
        end
    end

    // Output buffer: group writeback at wr, drain from rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd <= '0;
            wr <= '0;
            for (int i = 0; i < SIZE; i++) obuf[i] <= '0;
        end else begin
            rd <= rd_nx;
            wr <= wr_nx;
            for (int i = 0; i < P; i++)
                if (last_tap && lane_on[i]) obuf[IW'(wr + PW'(i))] <= lane_y[i];
        end
    end

endmodule

// File: tb/tb_conv1d_stream_p.sv
// Directed bench: two convolver instances (LENX=8 and LENX=9), hand-computed
// expected output frames, latency and flow-control checks.
module tb_conv1d_stream_p;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [W-1:0]        fd, xd;
    logic                relu;
    logic [1:0]          vf, vx, ry, rf, rx, vy;
    logic [1:0][W-1:0]   dy;

    conv1d_stream_p #(.WIDTH(W), .LENX(8), .LENF(4), .P(2)) u_a (
        .clk(clk), .reset(rst_n),
        .s_data_in_f(fd), .s_valid_f(vf[0]), .s_ready_f(rf[0]),
        .s_data_in_x(xd), .s_valid_x(vx[0]), .s_ready_x(rx[0]),
        .relu_en(relu),
        .m_data_out_y(dy[0]), .m_valid_y(vy[0]), .m_ready_y(ry[0])
    );

    conv1d_stream_p #(.WIDTH(W), .LENX(9), .LENF(4), .P(2)) u_b (
        .clk(clk), .reset(rst_n),
        .s_data_in_f(fd), .s_valid_f(vf[1]), .s_ready_f(rf[1]),
        .s_data_in_x(xd), .s_valid_x(vx[1]), .s_ready_x(rx[1]),
        .relu_en(relu),
        .m_data_out_y(dy[1]), .m_valid_y(vy[1]), .m_ready_y(ry[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ya[$], yb[$];
    int exp_q[$], xs[$];
    int base [2] = '{0, 0};
    int lat [2] = '{-1, -1};
    int last_x [2] = '{0, 0};
    logic [1:0] pend = '0, vy_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture accepted outputs and first-valid latency after the last X word.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (vy[s] && ry[s]) begin
                if (s == 0) ya.push_back($signed(dy[0]));
                else        yb.push_back($signed(dy[1]));
            end
            if (vx[s] && rx[s]) begin
                last_x[s] <= cyc;
                pend[s]   <= 1'b1;
            end else if (vy[s] && !vy_d[s] && pend[s]) begin
                lat[s]  <= cyc - last_x[s];
                pend[s] <= 1'b0;
            end
            vy_d[s] <= vy[s];
        end
    end

    function automatic int got_n(input int s);
        return (s == 0) ? ya.size() : yb.size();
    endfunction

    function automatic int got_v(input int s, input int i);
        return (s == 0) ? ya[i] : yb[i];
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_f(input int s, input int v);
        int c = 0;
        fd = W'(v);
        vf[s] = 1'b1;
        @(negedge clk);
        while (!rf[s] && c < 500) begin @(negedge clk); c++; end
        if (!rf[s]) chk("f_tmo", int'(rf[s]), 1);
        @(posedge clk); #1;
        vf[s] = 1'b0;
    endtask

    task automatic send_x(input int s, input int v, input logic r);
        int c = 0;
        xd = W'(v);
        relu = r;
        vx[s] = 1'b1;
        @(negedge clk);
        while (!rx[s] && c < 500) begin @(negedge clk); c++; end
        if (!rx[s]) chk("x_tmo", int'(rx[s]), 1);
        @(posedge clk); #1;
        vx[s] = 1'b0;
    endtask

    task automatic send_frame(input int s, input logic r0, input logic r1);
        for (int i = 0; i < xs.size(); i++) send_x(s, xs[i], (i == 0) ? r0 : r1);
    endtask

    task automatic fill_ramp(input int a, input int n);
        xs.delete();
        for (int i = 0; i < n; i++) xs.push_back(a + i);
    endtask

    task automatic fill_const(input int v, input int n);
        xs.delete();
        repeat (n) xs.push_back(v);
    endtask

    task automatic exp_const(input int v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic check_out(input int s, input string tag);
        int c = 0;
        while ((got_n(s) - base[s] < exp_q.size()) && c < 3000) begin @(negedge clk); c++; end
        repeat (12) @(negedge clk);
        chk({tag, "_cnt"}, got_n(s) - base[s], exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_n(s) - base[s]; i++)
            chk($sformatf("%s_y%0d", tag, i), got_v(s, base[s] + i), exp_q[i]);
        base[s] = got_n(s);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; fd = '0; xd = '0; relu = 1'b0;
        vf = '0; vx = '0; ry = 2'b11;
        #1 rst_n = 1'b0;
        tick(3);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_rdyf", int'(rf[s]), 1);
            chk("rst_rdyx", int'(rx[s]), 0);
            chk("rst_vy",   int'(vy[s]), 0);
            chk("rst_dy",   $signed(dy[s]), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // Box filter over a ramp; odd SIZE leaves lane 1 idle in the last group.
        repeat (4) send_f(0, 1);
        fill_ramp(1, 8);
        send_frame(0, 1'b0, 1'b0);
        exp_q = '{10, 14, 18, 22, 26};
        check_out(0, "box");
        chk("box_lat", lat[0], 5);

        // Stall drain, load the next frame into the waiting X buffer.
        ry[0] = 1'b0;
        fill_ramp(10, 8);
        send_frame(0, 1'b0, 1'b0);
        fill_const(2, 8);
        send_frame(0, 1'b0, 1'b0);
        tick(2);
        @(negedge clk);
        chk("stall_rdyx", int'(rx[0]), 0);
        chk("stall_vy",   int'(vy[0]), 1);
        chk("stall_hold", got_n(0) - base[0], 0);
        @(posedge clk); #1;
        tick(40);
        fork
            begin
                repeat (60) begin ry[0] = ~ry[0]; tick(1); end
                ry[0] = 1'b1;
            end
            begin
                fill_const(-3, 8);
                send_frame(0, 1'b0, 1'b0);
            end
        join
        exp_q = '{46, 50, 54, 58, 62};
        exp_const(8, 5);
        exp_const(-12, 5);
        check_out(0, "stall");

        // Reset during COMPUTE: nothing is written, filter must be reloaded.
        fill_ramp(1, 8);
        send_frame(0, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rdyf", int'(rf[0]), 1);
        chk("mid_rdyx", int'(rx[0]), 0);
        chk("mid_vy",   int'(vy[0]), 0);
        chk("mid_dy",   $signed(dy[0]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(20);
        chk("mid_noy", got_n(0) - base[0], 0);

        // Positive saturation.
        repeat (4) send_f(0, 127);
        fill_const(127, 8);
        send_frame(0, 1'b0, 1'b0);
        exp_const(127, 5);
        check_out(0, "satp");

        // Negative saturation, ReLU, and ReLU latched at the first X word.
        pulse_reset();
        repeat (4) send_f(0, -127);
        send_frame(0, 1'b0, 1'b0);
        exp_const(-128, 5);
        check_out(0, "satn");
        send_frame(0, 1'b1, 1'b1);
        exp_const(0, 5);
        check_out(0, "relu");
        send_frame(0, 1'b1, 1'b0);
        exp_const(0, 5);
        check_out(0, "latch1");
        send_frame(0, 1'b0, 1'b1);
        exp_const(-128, 5);
        check_out(0, "latch0");

        // Asymmetric filter on LENX=9: y[j] = 5j+14, exactly six outputs.
        send_f(1, 1);
        send_f(1, 2);
        send_f(1, -1);
        send_f(1, 3);
        fill_ramp(1, 9);
        send_frame(1, 1'b0, 1'b0);
        exp_q = '{14, 19, 24, 29, 34, 39};
        check_out(1, "odd");
        chk("odd_lat", lat[1], 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv1d_stream_p.md
# conv1d_stream_p

Streaming 1-D valid-mode convolution engine with P parallel MAC lanes. It computes y[j] = sum over k of x[j+k]·f[k], for j = 0..LENX-LENF. The filter is loaded at runtime over its own stream rather than fixed in a ROM. It adds full-precision accumulation with a single final saturation, a selectable ReLU mode, and an output buffer that drains while the next X frame loads. It sits between the X input stream and the Y output stream, in place of the single-generation fixed-ROM convolver.

## Interface
Parameters:
- WIDTH, 16, signed data width of x, f and y
- LENX, 16, samples per X frame (N)
- LENF, 4, filter taps (M); LENF ≤ LENX
- P, 2, parallel MAC lanes; 1 ≤ P ≤ SIZE
- SIZE, LENX-LENF+1 (derived, not overridable), outputs per frame

Ports:
- clk  in  1  clock; all flops on rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- s_data_in_f  in  WIDTH  filter coefficient, f[0] first
- s_valid_f  in  1  filter word valid
- s_ready_f  out  1  filter word accepted when s_valid_f & s_ready_f
- s_data_in_x  in  WIDTH  input sample, x[0] first
- s_valid_x  in  1  sample valid
- s_ready_x  out  1  sample accepted when s_valid_x & s_ready_x
- relu_en  in  1  mode: clamp negative results to 0; sampled on the first X handshake of each frame
- m_data_out_y  out  WIDTH  output sample, y[0] first
- m_valid_y  out  1  output valid
- m_ready_y  in  1  output accepted when m_valid_y & m_ready_y

## Operation
- States:
  - LOAD_F: accept LENF words into f[0..LENF-1], then go to LOAD_X. Entered only from reset; the filter is retained across frames.
  - LOAD_X: s_ready_x = (xcnt < LENX). Go to COMPUTE when xcnt == LENX and the output buffer is empty.
  - COMPUTE: s_ready_x = 0. Process ceil(SIZE/P) groups. For group g, lane i produces y[g·P+i] over LENF MAC cycles using x[g·P+i+k]·f[k], k = 0..LENF-1.
- Output-buffer emptiness for the LOAD_X exit: rd == wr == 0 after clear.
- Leaving COMPUTE: return to LOAD_X with xcnt = 0 after the last group write.
- X buffer is a register array with combinational P-way read.
- Lanes whose index g·P+i ≥ SIZE are held cleared and never written.
- Arithmetic:
  - Each product is full 2·WIDTH.
  - Accumulator is 2·WIDTH + clog2(LENF) bits; it does not saturate mid-sum.
  - At writeback, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - If the frame's latched relu_en = 1, clamp negative results to 0.
- Output buffer: SIZE entries with write pointer wr and read pointer rd.
  - A group write stores up to P results at wr and advances wr.
  - m_valid_y = (rd < wr); m_data_out_y = obuf[rd].
  - rd advances on each handshake. When rd reaches SIZE, clear rd and wr to 0.
- Draining overlaps the next LOAD_X.

## Timing
- Reset values:
  - state = LOAD_F; xcnt = fcnt = 0; rd = wr = 0.
  - s_ready_f = 1, s_ready_x = 0, m_valid_y = 0, m_data_out_y = 0.
  - Accumulators and buffers are cleared.
- All ready and valid outputs are registered-state functions, with no combinational path from a valid or ready input.
- Last X handshake at cycle t, output buffer empty:
  - COMPUTE runs cycles t+1..t+LENF for group 0.
  - The first write lands at the edge ending cycle t+LENF, so m_valid_y = 1 in cycle t+LENF+1.
  - Each subsequent group takes LENF cycles back-to-back.
- Simultaneous events:
  - Final Y handshake and final X handshake in the same cycle: enter COMPUTE next cycle.
  - Group write and Y handshake in the same cycle: both pointers update.
- s_valid_x while s_ready_x = 0 is ignored, and the data is not consumed. The same holds for s_valid_f outside LOAD_F.
- m_ready_y held low stalls only the drain. COMPUTE continues because the buffer holds SIZE entries.
- Reset asserted mid-frame: immediate return to reset values. The filter is lost and LOAD_F is required again.

## Structure
- Package conv1d_pkg holds:
  - the state enum (LOAD_F, LOAD_X, COMPUTE)
  - localparams ACCW = 2·WIDTH+$clog2(LENF), NGROUP = ceil(SIZE/P)
  - function sat_relu(acc, relu) returning WIDTH bits
- Sub-module conv_mac_lane (one per lane, generate loop): ports clk, reset, clr, en, x, f, acc out.
- Controller, X array, filter registers and output buffer stay in conv1d_stream_p.

## Test plan
- WIDTH=8, LENX=8, LENF=4, P=2: f = {1,1,1,1}, x = 1..8, relu_en=0 → y = 10,14,18,22,26, first m_valid_y exactly LENF+1 cycles after the last X handshake.
- Saturation: f all 127, x all 127 → every y = 127. Negate f → every y = -128 with relu_en=0, and 0 with relu_en=1.
- Odd SIZE (LENX=9, LENF=4, P=2): exactly 6 outputs, no extra m_valid_y, the unused lane in the last group is never written.
- m_ready_y low for 50 cycles then toggled every other cycle while the next frame streams in → no lost or duplicated y. s_ready_x drops at xcnt = LENX and COMPUTE waits for the drain.
- Reset pulled low during COMPUTE → next cycle s_ready_f = 1, m_valid_y = 0. Reload the filter and frame and get correct results.
- relu_en toggled mid-frame → the frame uses the value latched at its first X handshake.
